// File: rtl/fib_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fib_pkg : constants and types shared by the Fibonacci core and its BCD stage
// Revision: 1.0
// ---------------------------------------------------------------------------
package fib_pkg;

  localparam int fib_width  = 16;
  localparam int bcd_digits = 5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } bcd_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit_adj : double-dabble nibble correction, add 3 when the digit is >= 5
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/fib_bcd_convert.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fib_bcd_convert : sequential binary-to-BCD converter with one pending slot
// Revision: 1.0
// ---------------------------------------------------------------------------
module fib_bcd_convert
  import fib_pkg::*;
#(
  parameter int WIDTH  = fib_width,
  parameter int DIGITS = bcd_digits
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int REG_W = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  bcd_state_t          state;
  logic [REG_W-1:0]    work;
  logic [REG_W-1:0]    adjusted;
  logic [REG_W-1:0]    shifted;
  logic [4*DIGITS-1:0] adj_bcd;
  logic [CNT_W-1:0]    count;
  logic                pend_valid;
  logic [WIDTH-1:0]    pend_data;

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      bcd_digit_adj u_adj (
        .din  (work[WIDTH + 4*d +: 4]),
        .dout (adj_bcd[4*d +: 4])
      );
    end
  endgenerate

  // The top bit shifted out is always zero when DIGITS is sized correctly.
  assign adjusted = {adj_bcd, work[WIDTH-1:0]};
  assign shifted  = adjusted << 1;
  assign in_ready = ~pend_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      work       <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      bcd_out    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            work  <= {{(4*DIGITS){1'b0}}, pend_data};
            count <= '0;
            busy  <= 1'b1;
            state <= CONV;
            // Slot is refilled on the same edge it is drained.
            if (in_valid) begin
              pend_data <= in_data;
            end else begin
              pend_valid <= 1'b0;
            end
          end else if (in_valid) begin
            work  <= {{(4*DIGITS){1'b0}}, in_data};
            count <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end

        CONV: begin
          work  <= shifted;
          count <= count + 1'b1;
          if (count == LAST) begin
            bcd_out   <= shifted[REG_W-1:WIDTH];
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          if (in_valid) begin
            if (!pend_valid) begin
              pend_valid <= 1'b1;
              pend_data  <= in_data;
            end else begin
              overflow <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
